// File: rtl/elevator_request_latch_if.sv
// Signal bundle between the elevator controller side and the request latch.
// There is no valid/ready handshake on this bus: the buttons are raw
// asynchronous levels and the controller fields (ac, display, door_open) are
// plain levels. The latch samples all of them on every rising clock edge.
// The req_* / last_dir_up outputs are registered levels that are valid every cycle.
interface elevator_request_latch_if;
   logic [2:0] f_btn;
   logic [1:0] u_btn;
   logic [1:0] d_btn;
   logic [1:0] ac;
   logic [1:0] display;
   logic       door_open;
   logic [2:0] req_f;
   logic [2:0] req_u;
   logic [2:0] req_d;
   logic       req_any;
   logic       last_dir_up;

   // Controller / button side: drives buttons and status, reads pending requests
   modport master (
      output f_btn, u_btn, d_btn, ac, display, door_open,
      input  req_f, req_u, req_d, req_any, last_dir_up
   );

   // Request latch side
   modport slave (
      input  f_btn, u_btn, d_btn, ac, display, door_open,
      output req_f, req_u, req_d, req_any, last_dir_up
   );
endinterface

// File: rtl/elevator_request_latch.sv
// Elevator request front end: 2-flop synchronizer and counter debounce for
// the seven push-buttons, sticky pending-request bits that clear when the
// controller opens the door at a floor, and last-travel-direction tracking
// used to pick which floor-2 hall call is serviced.
// Button vector layout: [2:0] cabin floors 1..3, [4:3] hall-up floors 1..2,
// [6:5] hall-down floors 2..3.
module elevator_request_latch #(
   parameter int DEB_CYCLES = 4
) (
   input logic                     clk,
   input logic                     rst,
   elevator_request_latch_if.slave bus
);

   localparam int NB    = 7;
   localparam int CNT_W = $clog2(DEB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [NB-1:0]    raw;
   logic [NB-1:0]    sync1;
   logic [NB-1:0]    s;
   logic [NB-1:0]    db;
   logic [CNT_W-1:0] cnt [NB];
   logic [NB-1:0]    accept;

   logic [2:0] set_f, set_u, set_d;
   logic [2:0] clr_f, clr_u, clr_d;
   logic [2:0] nxt_f, nxt_u, nxt_d;

   logic [2:0] req_f_q, req_u_q, req_d_q;
   logic       req_any_q;
   logic       dir_up_q;

   assign raw = {bus.d_btn, bus.u_btn, bus.f_btn};

   // Two-flop synchronizer for every raw button level
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         s     <= '0;
      end else begin
         sync1 <= raw;
         s     <= sync1;
      end
   end

   // Debounce: a new level must persist DEB_CYCLES synchronized cycles;
   // any return to the debounced level restarts the count
   always_ff @(posedge clk) begin
      if (rst) begin
         db <= '0;
         for (int i = 0; i < NB; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NB; i++) begin
            if (s[i] == db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               db[i]  <= s[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_ONE;
            end
         end
      end
   end

   // A press is accepted on the cycle the debounced level rises
   always_comb begin
      accept = '0;
      for (int i = 0; i < NB; i++) begin
         accept[i] = s[i] & ~db[i] & (cnt[i] == CNT_LAST);
      end
   end

   // Map accepted presses onto per-floor request bits
   always_comb begin
      set_f = accept[2:0];
      set_u = {1'b0, accept[4:3]};
      set_d = {accept[6:5], 1'b0};
   end

   // Service clear at the floor shown while the door is open; at floor 2
   // only the hall call matching the last travel direction is serviced
   always_comb begin
      clr_f = '0;
      clr_u = '0;
      clr_d = '0;
      if (bus.door_open) begin
         case (bus.display)
            2'd1: begin
               clr_f[0] = 1'b1;
               clr_u[0] = 1'b1;
            end
            2'd2: begin
               clr_f[1] = 1'b1;
               if (dir_up_q) clr_u[1] = 1'b1;
               else          clr_d[1] = 1'b1;
            end
            2'd3: begin
               clr_f[2] = 1'b1;
               clr_d[2] = 1'b1;
            end
            default: begin
               clr_f = '0;
            end
         endcase
      end
   end

   // Next pending state: clear wins over a same-cycle set; the top hall-up
   // and bottom hall-down bits do not exist and are forced low
   always_comb begin
      nxt_f = (req_f_q | set_f) & ~clr_f;
      nxt_u = (req_u_q | set_u) & ~clr_u & 3'b011;
      nxt_d = (req_d_q | set_d) & ~clr_d & 3'b110;
   end

   // Pending request registers, with req_any registered from the next state
   // so it lines up with the req_* bits
   always_ff @(posedge clk) begin
      if (rst) begin
         req_f_q   <= '0;
         req_u_q   <= '0;
         req_d_q   <= '0;
         req_any_q <= 1'b0;
      end else begin
         req_f_q   <= nxt_f;
         req_u_q   <= nxt_u;
         req_d_q   <= nxt_d;
         req_any_q <= |{nxt_f, nxt_u, nxt_d};
      end
   end

   // Remember the last nonzero motor command direction
   always_ff @(posedge clk) begin
      if (rst) begin
         dir_up_q <= 1'b1;
      end else begin
         case (bus.ac)
            2'b10:   dir_up_q <= 1'b1;
            2'b01:   dir_up_q <= 1'b0;
            default: dir_up_q <= dir_up_q;
         endcase
      end
   end

   assign bus.req_f       = req_f_q;
   assign bus.req_u       = req_u_q;
   assign bus.req_d       = req_d_q;
   assign bus.req_any     = req_any_q;
   assign bus.last_dir_up = dir_up_q;

endmodule

// File: tb/tb_elevator_request_latch.sv
// Bench for elevator_request_latch: directed vector table, hand sequences for
// the multi-cycle corners, then randomized traffic against a reference model.
module tb_elevator_request_latch;

   localparam int DEB = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   elevator_request_latch_if bus ();

   elevator_request_latch #(.DEB_CYCLES(DEB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- scoreboard state ----------------
   int n_cmp  = 0;
   int n_fail = 0;
   logic [10:0] exp_q[$];

   // ---------------- reference model ----------------
   // Model view: the synchronized level is the raw level two edges old; a
   // button's debounced level flips once its last DEB synchronized samples
   // all disagree with it. Pending requests are kept per floor.
   logic [6:0] m_raw_q[$];
   logic [6:0] m_s_hist[$];
   logic [6:0] m_db  = '0;
   logic [2:0] m_cab = '0;
   logic [2:0] m_up  = '0;
   logic [2:0] m_dn  = '0;
   logic       m_dir = 1'b1;

   function automatic logic [10:0] model_out();
      return {m_cab, m_up, m_dn, |{m_cab, m_up, m_dn}, m_dir};
   endfunction

   function automatic logic [10:0] dut_out();
      return {bus.req_f, bus.req_u, bus.req_d, bus.req_any, bus.last_dir_up};
   endfunction

   task automatic model_edge();
      logic [6:0] s_now;
      logic [6:0] acc;
      int fl;
      if (rst) begin
         m_raw_q = '{7'd0, 7'd0};
         m_s_hist.delete();
         for (int k = 0; k < DEB; k++) m_s_hist.push_back(7'd0);
         m_db  = '0;
         m_cab = '0;
         m_up  = '0;
         m_dn  = '0;
         m_dir = 1'b1;
      end else begin
         s_now = m_raw_q.pop_front();
         m_raw_q.push_back({bus.d_btn, bus.u_btn, bus.f_btn});
         void'(m_s_hist.pop_front());
         m_s_hist.push_back(s_now);
         acc = '0;
         for (int i = 0; i < 7; i++) begin
            logic all_diff;
            all_diff = 1'b1;
            foreach (m_s_hist[k]) if (m_s_hist[k][i] == m_db[i]) all_diff = 1'b0;
            if (all_diff) begin
               if (!m_db[i]) acc[i] = 1'b1;
               m_db[i] = ~m_db[i];
            end
         end
         m_cab = m_cab | acc[2:0];
         if (acc[3]) m_up[0] = 1'b1;
         if (acc[4]) m_up[1] = 1'b1;
         if (acc[5]) m_dn[1] = 1'b1;
         if (acc[6]) m_dn[2] = 1'b1;
         if (bus.door_open && bus.display != 2'd0) begin
            fl = int'(bus.display) - 1;
            m_cab[fl] = 1'b0;
            if (fl == 0)      m_up[0] = 1'b0;
            else if (fl == 2) m_dn[2] = 1'b0;
            else if (m_dir)   m_up[1] = 1'b0;
            else              m_dn[1] = 1'b0;
         end
         if (bus.ac == 2'b10)      m_dir = 1'b1;
         else if (bus.ac == 2'b01) m_dir = 1'b0;
      end
      exp_q.push_back(model_out());
   endtask

   // ---------------- comparison helpers ----------------
   task automatic chk11(input string name, input logic [10:0] act, input logic [10:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk3(input string name, input logic [2:0] act, input logic [2:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [2:0] f, input logic [1:0] u, input logic [1:0] d,
                        input logic [1:0] ac, input logic [1:0] disp, input logic door);
      bus.f_btn     = f;
      bus.u_btn     = u;
      bus.d_btn     = d;
      bus.ac        = ac;
      bus.display   = disp;
      bus.door_open = door;
   endtask

   // One clock: model steps at the edge, DUT checked against the model on the falling edge
   task automatic step();
      logic [10:0] e;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      e = exp_q.pop_front();
      chk11("model", dut_out(), e);
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic       rst;
      logic [2:0] f;
      logic [1:0] u;
      logic [1:0] d;
      logic [1:0] ac;
      logic [1:0] disp;
      logic       door;
      logic [2:0] ef;
      logic [2:0] eu;
      logic [2:0] ed;
      logic       eany;
      logic       edir;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic [2:0] f, input logic [1:0] u, input logic [1:0] d,
                      input logic [1:0] ac, input logic [1:0] disp, input logic door,
                      input logic [2:0] ef, input logic [2:0] eu, input logic [2:0] ed,
                      input logic eany, input logic edir);
      vec_t v;
      v.rst = r; v.f = f; v.u = u; v.d = d; v.ac = ac; v.disp = disp; v.door = door;
      v.ef = ef; v.eu = eu; v.ed = ed; v.eany = eany; v.edir = edir;
      tbl.push_back(v);
   endtask

   // ---------------- random stimulus state ----------------
   logic [6:0] r_lvl;
   int         r_hold [7];

   initial begin
      drive(3'b000, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0);

      // Reset with all buttons held, release, all presses land on the
      // sixth edge after release; then direction tracking and floor clears.
      add(1, 3'b111, 2'b11, 2'b11, 2'b00, 2'd0, 0, 3'b000, 3'b000, 3'b000, 0, 1);
      add(1, 3'b111, 2'b11, 2'b11, 2'b00, 2'd0, 0, 3'b000, 3'b000, 3'b000, 0, 1);
      for (int k = 0; k < 5; k++)
         add(0, 3'b111, 2'b11, 2'b11, 2'b00, 2'd0, 0, 3'b000, 3'b000, 3'b000, 0, 1);
      add(0, 3'b111, 2'b11, 2'b11, 2'b00, 2'd0, 0, 3'b111, 3'b011, 3'b110, 1, 1);
      add(0, 3'b000, 2'b00, 2'b00, 2'b01, 2'd0, 0, 3'b111, 3'b011, 3'b110, 1, 0);
      add(0, 3'b000, 2'b00, 2'b00, 2'b11, 2'd0, 0, 3'b111, 3'b011, 3'b110, 1, 0);
      add(0, 3'b000, 2'b00, 2'b00, 2'b00, 2'd1, 1, 3'b110, 3'b010, 3'b110, 1, 0);
      add(0, 3'b000, 2'b00, 2'b00, 2'b00, 2'd3, 1, 3'b010, 3'b010, 3'b010, 1, 0);
      add(0, 3'b000, 2'b00, 2'b00, 2'b00, 2'd2, 1, 3'b000, 3'b010, 3'b000, 1, 0);
      add(0, 3'b000, 2'b00, 2'b00, 2'b10, 2'd0, 0, 3'b000, 3'b010, 3'b000, 1, 1);
      add(0, 3'b000, 2'b00, 2'b00, 2'b00, 2'd0, 1, 3'b000, 3'b010, 3'b000, 1, 1);
      add(0, 3'b000, 2'b00, 2'b00, 2'b00, 2'd2, 1, 3'b000, 3'b000, 3'b000, 0, 1);
      add(0, 3'b000, 2'b00, 2'b00, 2'b00, 2'd0, 0, 3'b000, 3'b000, 3'b000, 0, 1);

      for (int i = 0; i < tbl.size(); i++) begin
         rst = tbl[i].rst;
         drive(tbl[i].f, tbl[i].u, tbl[i].d, tbl[i].ac, tbl[i].disp, tbl[i].door);
         step();
         chk3($sformatf("tbl[%0d].req_f", i), bus.req_f, tbl[i].ef);
         chk3($sformatf("tbl[%0d].req_u", i), bus.req_u, tbl[i].eu);
         chk3($sformatf("tbl[%0d].req_d", i), bus.req_d, tbl[i].ed);
         chk1($sformatf("tbl[%0d].req_any", i), bus.req_any, tbl[i].eany);
         chk1($sformatf("tbl[%0d].last_dir_up", i), bus.last_dir_up, tbl[i].edir);
      end
      drive(3'b000, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0);
      run(8);

      // Glitch: 3 high cycles are rejected, 4 high cycles are accepted
      drive(3'b100, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0);
      run(3);
      drive(3'b000, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0);
      run(8);
      chk3("glitch_short", bus.req_f, 3'b000);
      drive(3'b100, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0);
      run(4);
      drive(3'b000, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0);
      run(1);
      chk3("glitch4_early", bus.req_f, 3'b000);
      run(1);
      chk3("glitch4_accept", bus.req_f, 3'b100);
      run(6);
      chk3("glitch4_hold", bus.req_f, 3'b100);
      drive(3'b000, 2'b00, 2'b00, 2'b00, 2'd3, 1'b1);
      run(1);
      chk3("clear_f3", bus.req_f, 3'b000);
      drive(3'b000, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0);
      run(2);

      // Bounce on hall-up floor 1: pattern 1,1,0,1,1,1,1
      begin
         logic [6:0] pat;
         pat = 7'b1111011;
         for (int k = 0; k < 7; k++) begin
            drive(3'b000, {1'b0, pat[k]}, 2'b00, 2'b00, 2'd0, 1'b0);
            step();
         end
      end
      chk3("bounce_mid", bus.req_u, 3'b000);
      drive(3'b000, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0);
      run(1);
      chk3("bounce_early", bus.req_u, 3'b000);
      run(1);
      chk3("bounce_accept", bus.req_u, 3'b001);
      chk1("bounce_any", bus.req_any, 1'b1);
      run(6);
      chk3("bounce_once", bus.req_u, 3'b001);
      drive(3'b000, 2'b00, 2'b00, 2'b00, 2'd1, 1'b1);
      run(1);
      chk1("clear_f1_any", bus.req_any, 1'b0);
      drive(3'b000, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0);
      run(2);

      // Floor 2 direction-qualified clear, going up
      drive(3'b000, 2'b10, 2'b01, 2'b00, 2'd0, 1'b0);
      run(6);
      chk3("f2_set_u", bus.req_u, 3'b010);
      chk3("f2_set_d", bus.req_d, 3'b010);
      drive(3'b000, 2'b00, 2'b00, 2'b10, 2'd0, 1'b0);
      run(1);
      drive(3'b000, 2'b00, 2'b00, 2'b00, 2'd2, 1'b1);
      run(1);
      chk3("f2_up_u", bus.req_u, 3'b000);
      chk3("f2_up_d", bus.req_d, 3'b010);
      drive(3'b000, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0);
      run(8);
      // Floor 2, going down
      drive(3'b000, 2'b10, 2'b00, 2'b00, 2'd0, 1'b0);
      run(6);
      drive(3'b000, 2'b00, 2'b00, 2'b01, 2'd0, 1'b0);
      run(1);
      drive(3'b000, 2'b00, 2'b00, 2'b00, 2'd2, 1'b1);
      run(1);
      chk3("f2_dn_u", bus.req_u, 3'b010);
      chk3("f2_dn_d", bus.req_d, 3'b000);
      drive(3'b000, 2'b00, 2'b00, 2'b10, 2'd0, 1'b0);
      run(1);
      drive(3'b000, 2'b00, 2'b00, 2'b00, 2'd2, 1'b1);
      run(1);
      chk1("f2_done_any", bus.req_any, 1'b0);
      drive(3'b000, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0);
      run(8);

      // Collision: press accepted while door open at the same floor
      drive(3'b001, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0);
      run(5);
      drive(3'b001, 2'b00, 2'b00, 2'b00, 2'd1, 1'b1);
      run(1);
      chk3("collide_same", bus.req_f, 3'b000);
      chk1("collide_same_any", bus.req_any, 1'b0);
      drive(3'b000, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0);
      run(8);
      drive(3'b001, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0);
      run(5);
      drive(3'b001, 2'b00, 2'b00, 2'b00, 2'd3, 1'b1);
      run(1);
      chk3("collide_other", bus.req_f, 3'b001);
      chk1("collide_other_any", bus.req_any, 1'b1);
      drive(3'b000, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0);
      run(8);
      drive(3'b000, 2'b00, 2'b00, 2'b00, 2'd1, 1'b1);
      run(1);

      // Mid-operation reset with a half-debounced hall-down floor 3 press
      drive(3'b101, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0);
      run(6);
      chk3("mid_pre_f", bus.req_f, 3'b101);
      drive(3'b000, 2'b00, 2'b10, 2'b01, 2'd0, 1'b0);
      run(4);
      rst = 1'b1;
      run(1);
      chk11("mid_reset_all", dut_out(), {3'b000, 3'b000, 3'b000, 1'b0, 1'b1});
      rst = 1'b0;
      drive(3'b000, 2'b00, 2'b10, 2'b00, 2'd0, 1'b0);
      run(5);
      chk3("mid_post_early", bus.req_d, 3'b000);
      run(1);
      chk3("mid_post_accept", bus.req_d, 3'b100);
      drive(3'b000, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0);
      run(8);

      // Randomized traffic against the model
      r_lvl = '0;
      for (int i = 0; i < 7; i++) r_hold[i] = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         for (int i = 0; i < 7; i++) begin
            if (r_hold[i] == 0) begin
               r_lvl[i]  = $urandom_range(0, 1) == 1;
               r_hold[i] = $urandom_range(1, 12);
            end else begin
               r_hold[i]--;
            end
         end
         rst = ($urandom_range(0, 299) == 0);
         drive(r_lvl[2:0], r_lvl[4:3], r_lvl[6:5], 2'($urandom_range(0, 3)),
               2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
         step();
      end

      chk11("queue_drained", 11'(exp_q.size()), 11'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/elevator_request_latch.md
Name: elevator_request_latch

Overview:
Front-end request stage that sits directly upstream of the elevator controller FSM. It synchronizes and debounces the raw cabin and hall push-buttons, and turns each accepted press into a sticky pending-request bit. Each pending bit holds until the controller services that floor with the door open. It also tracks the car's last travel direction so that only the matching hall call at floor 2 is cleared.

Parameters:
DEB_CYCLES, 4, consecutive synchronized cycles a button level must differ from its debounced level before it is accepted (≥1)
CNT_W, $clog2(DEB_CYCLES+1), width of each debounce counter (derived, not overridden)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
f_btn  input  3  raw cabin buttons, bit i = floor i+1, asynchronous
u_btn  input  2  raw hall-up buttons, floors 1..2, asynchronous
d_btn  input  2  raw hall-down buttons, bit 0 = floor 2, bit 1 = floor 3, asynchronous
ac  input  2  controller motor command: 2'b10 up, 2'b01 down, 2'b00 stop
display  input  2  controller floor indication: 1..3 valid, 0 = none
door_open  input  1  controller door-open output
req_f  output  3  pending cabin requests, bit i = floor i+1
req_u  output  3  pending hall-up requests, bit i = floor i+1; bit 2 constant 0
req_d  output  3  pending hall-down requests, bit i = floor i+1; bit 0 constant 0
req_any  output  1  OR of all pending bits (registered)
last_dir_up  output  1  1 = last nonzero ac was up, 0 = down

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: all req_* = 0, req_any = 0, last_dir_up = 1, sync flops = 0, debounced levels = 0, counters = 0. Reset mid-operation discards all pending and in-flight presses.
- Button pipeline: there are 7 physical buttons, each handled independently.
  - Synchronizer: sync1 <= raw; s <= sync1.
  - Debounce, per button, with state db (debounced level) and cnt:
    - if s == db: cnt <= 0.
    - else if cnt == DEB_CYCLES-1: db <= s, cnt <= 0.
    - else: cnt <= cnt+1.
  - Press accept: asserted in the same cycle db goes 0→1 (cnt == DEB_CYCLES-1, s = 1, db = 0).
  - A db falling transition has no effect on requests.
- Latency: if raw is high at edge 0 (first sampling edge) and stays high, the req bit reads 1 after edge DEB_CYCLES+1. With DEB_CYCLES = 4 that is after edge 5.
- Glitch rejection: a pulse with fewer than DEB_CYCLES consecutive synchronized-high cycles never sets a request. Any bounce back to s == db restarts the count.
- Pending set: an accepted press sets its req bit. Pressing an already-pending button leaves it at 1.
- Direction tracking, updated every cycle:
  - ac == 2'b10 → last_dir_up <= 1.
  - ac == 2'b01 → last_dir_up <= 0.
  - ac == 2'b00 or 2'b11 → hold.
- Service clear: active on any cycle with door_open == 1 and display == N (N in 1..3). Level-sensitive, repeats every such cycle.
  - Always clear req_f[N-1].
  - N = 1: clear req_u[0].
  - N = 3: clear req_d[2].
  - N = 2: clear req_u[1] if last_dir_up, else clear req_d[1].
  - display == 0 with door_open high: no clear.
- Set/clear collision: if an accepted press and a service clear hit the same bit in the same cycle, clear wins and the bit ends at 0. Presses at the open door are absorbed.
- Different bits: set and clear of different bits in the same cycle are independent and both take effect.
- req_any: registered, equal to the OR of the next-state req bits, so it is aligned with req_* (no extra cycle).
- Constant bits: req_u[2] and req_d[0] are tied 0 at all times.
- Output registers: all outputs come directly from registers, with no combinational path from inputs.

Test Plan:
- Reset with DEB_CYCLES = 4: hold rst for 2 cycles with all buttons high → all req_* = 0, req_any = 0, last_dir_up = 1 during and after reset. Release rst → req_f = 3'b111 after edge 5 post-release, plus matching hall bits.
- Glitch: f_btn[2] high for 3 cycles then low → req_f stays 3'b000. Same button high for 4 cycles → req_f = 3'b100 after edge 5 and stays 3'b100 after release.
- Bounce: u_btn[0] pattern 1,1,0,1,1,1,1 → req_u[0] rises only after the final 4-cycle stable run completes. Exactly one set, req_any = 1.
- Floor-2 direction clear:
  - Set req_u[1] and req_d[1], drive ac = 2'b10 for 1 cycle, then ac = 0, display = 2, door_open = 1 → req_u = 3'b000, req_d = 3'b010.
  - Repeat with ac = 2'b01 → req_d[1] clears and req_u[1] is retained.
- Collision: accepted f_btn[0] press lands in a cycle with door_open = 1 and display = 1 → req_f[0] = 0 and req_any unchanged. The same press with display = 3 → req_f[0] = 1.
- Mid-operation reset: with req_f = 3'b101 pending and a d_btn[1] press half-debounced, pulse rst for 1 cycle → all req_* = 0. d_btn[1] held high afterwards is accepted exactly DEB_CYCLES+2 edges after rst deasserts (2 synchronizer edges + DEB_CYCLES debounce edges).
